// File: rtl/mii_mirror_pkg.sv
// Shared sizes, default link location and the capture pipeline record
// for the MII register mirror.
package mii_mirror_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 16;

  // BMSR register index and its link-status bit.
  localparam int LINK_REG_DEF = 1;
  localparam int LINK_BIT_DEF = 2;

  // One capture pipeline stage: the captured register plus the value the
  // mirror held for it before this capture (filled in stage 1).
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] old;
  } stage_t;

endpackage

// File: rtl/mii_mirror_ram.sv
// 32x16 mirror storage: one write port, one asynchronous compare read port,
// one registered host read port. No storage reset, so it maps onto
// distributed RAM; only the host read register is cleared.
module mii_mirror_ram
  import mii_mirror_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] cmp_addr,
  output logic [DW-1:0] cmp_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [NREG];

  // Write port: commit stage writes the captured value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Compare port: combinational read of the pre-commit contents.
  assign cmp_data = mem[cmp_addr];

  // Host port: registered read; same-cycle write is not bypassed, so a read
  // of the committing address returns the old value.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mii_reg_mirror.sv
// Mirror of the 32 PHY management registers fed by the MDIO polling engine.
// Tracks which registers have been captured, sticky per-register change
// flags, sweep completion, and link status with a change pulse.
//
// Handshake: strobe is a one-cycle valid qualifier for addr/data with no
// ready; every strobe is accepted, one per cycle, back-to-back allowed.
module mii_reg_mirror
  import mii_mirror_pkg::*;
#(
  parameter logic [31:0] CHG_MASK = 32'hFFFF_FFFF,
  parameter int          LINK_REG = LINK_REG_DEF,
  parameter int          LINK_BIT = LINK_BIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic [31:0]   clr,
  output logic [31:0]   seen,
  output logic [31:0]   changed,
  output logic          all_seen,
  output logic          sweep_done,
  output logic [15:0]   sweep_count,
  output logic          link_up,
  output logic          link_event,
  output logic          irq
);

  localparam logic [AW-1:0] LINK_ADDR  = AW'(LINK_REG);
  localparam logic [AW-1:0] SWEEP_LAST = AW'(NREG - 1);

  stage_t        s1_q;
  stage_t        s2_q;
  logic [DW-1:0] cmp_data;
  logic [DW-1:0] old_fwd;
  logic [31:0]   seen_q;
  logic [31:0]   changed_q;
  logic [15:0]   sweep_count_q;
  logic          link_bit_q;
  logic [31:0]   commit_vec;
  logic [31:0]   set_vec;
  logic          link_commit;
  logic          link_new;

  mii_mirror_ram u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (s2_q.valid),
    .waddr    (s2_q.addr),
    .wdata    (s2_q.data),
    .cmp_addr (s1_q.addr),
    .cmp_data (cmp_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  // Stage-1 old value, forwarded from the commit stage when it targets the
  // same register so back-to-back captures compare as if serialised.
  always_comb begin
    old_fwd = cmp_data;
    if (s2_q.valid && (s2_q.addr == s1_q.addr)) old_fwd = s2_q.data;
  end

  // Capture pipeline: stage 1 latches the strobe, stage 2 is the commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q.valid <= strobe;
      s1_q.addr  <= addr;
      s1_q.data  <= data;
      s1_q.old   <= '0;
      s2_q.valid <= s1_q.valid;
      s2_q.addr  <= s1_q.addr;
      s2_q.data  <= s1_q.data;
      s2_q.old   <= old_fwd;
    end
  end

  // Commit decode: which bit is committed, whether it counts as a change,
  // and whether it touches the link register.
  always_comb begin
    commit_vec  = '0;
    if (s2_q.valid) commit_vec = 32'd1 << s2_q.addr;
    set_vec     = commit_vec & seen_q & CHG_MASK &
                  {32{s2_q.old != s2_q.data}};
    link_commit = s2_q.valid && (s2_q.addr == LINK_ADDR);
    link_new    = s2_q.data[LINK_BIT];
  end

  // Status flags and sweep counter; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q        <= '0;
      changed_q     <= '0;
      sweep_count_q <= '0;
    end else begin
      seen_q    <= seen_q | commit_vec;
      changed_q <= (changed_q & ~clr) | set_vec;
      if (s2_q.valid && (s2_q.addr == SWEEP_LAST))
        sweep_count_q <= sweep_count_q + 16'd1;
    end
  end

  // Shadow of the link bit so link_up needs no extra RAM read port; like the
  // mirror it is not reset and is qualified by seen.
  always_ff @(posedge clk) begin
    if (link_commit) link_bit_q <= link_new;
  end

  assign seen        = seen_q;
  assign changed     = changed_q;
  assign sweep_count = sweep_count_q;
  assign all_seen    = &seen_q;
  assign irq         = |changed_q;
  assign link_up     = link_bit_q & seen_q[LINK_REG];
  assign sweep_done  = s2_q.valid && (s2_q.addr == SWEEP_LAST);
  assign link_event  = link_commit && (link_new != link_up);

endmodule

// File: tb/tb_mii_reg_mirror.sv
// Directed bench for mii_reg_mirror. A second instance with CHG_MASK bit 9
// cleared shares the same stimulus.
module tb_mii_reg_mirror;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic [4:0]  addr = '0;
  logic [15:0] data = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] clr = '0;

  logic [15:0] rd_data, rd_data_m;
  logic [31:0] seen, seen_m, changed, changed_m;
  logic        all_seen, all_seen_m, sweep_done, sweep_done_m;
  logic [15:0] sweep_count, sweep_count_m;
  logic        link_up, link_up_m, link_event, link_event_m, irq, irq_m;

  int vec_cnt = 0;
  int err_cnt = 0;
  int sd_cnt  = 0;
  int le_cnt  = 0;
  logic [31:0] exp_q[$];

  mii_reg_mirror dut (
    .clk(clk), .rst(rst), .strobe(strobe), .addr(addr), .data(data),
    .rd_addr(rd_addr), .rd_data(rd_data), .clr(clr), .seen(seen),
    .changed(changed), .all_seen(all_seen), .sweep_done(sweep_done),
    .sweep_count(sweep_count), .link_up(link_up), .link_event(link_event),
    .irq(irq)
  );

  mii_reg_mirror #(.CHG_MASK(32'hFFFF_FDFF)) dut_m (
    .clk(clk), .rst(rst), .strobe(strobe), .addr(addr), .data(data),
    .rd_addr(rd_addr), .rd_data(rd_data_m), .clr(clr), .seen(seen_m),
    .changed(changed_m), .all_seen(all_seen_m), .sweep_done(sweep_done_m),
    .sweep_count(sweep_count_m), .link_up(link_up_m),
    .link_event(link_event_m), .irq(irq_m)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  // Pulse monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sweep_done) sd_cnt++;
    if (link_event) le_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns 1 unit after the sampling edge.
  task automatic send(input logic [4:0] a, input logic [15:0] d);
    strobe = 1'b1;
    addr   = a;
    data   = d;
    tick(1);
    strobe = 1'b0;
  endtask

  // Strobe then wait until just after its commit edge.
  task automatic send_wait(input logic [4:0] a, input logic [15:0] d);
    send(a, d);
    tick(2);
  endtask

  task automatic clear_all();
    clr = '1;
    tick(1);
    clr = '0;
  endtask

  task automatic link_case(input string tag, input logic [15:0] d,
                           input int exp_ev, input logic exp_up);
    int le0;
    le0 = le_cnt;
    send_wait(5'd1, d);
    tick(2);
    chk({tag, "_event"}, 32'(le_cnt - le0), 32'(exp_ev));
    chk({tag, "_up"}, 32'(link_up), 32'(exp_up));
  endtask

  initial begin
    // Reset state, sampled while rst is still high.
    tick(3);
    chk("rst_seen", seen, 32'h0);
    chk("rst_changed", changed, 32'h0);
    chk("rst_count", 32'(sweep_count), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_link_up", 32'(link_up), 32'h0);
    rst = 1'b0;
    tick(1);

    // First sweep, 64 cycles apart.
    for (int n = 0; n < 32; n++) begin
      send_wait(5'(n), 16'h1000 + 16'(n));
      if (n == 30) chk("sw1_all_seen_early", 32'(all_seen), 32'h0);
      tick(61);
    end
    chk("sw1_all_seen", 32'(all_seen), 32'h1);
    chk("sw1_seen", seen, 32'hFFFF_FFFF);
    chk("sw1_pulses", 32'(sd_cnt), 32'd1);
    chk("sw1_count", 32'(sweep_count), 32'd1);
    chk("sw1_changed", changed, 32'h0);
    chk("sw1_irq", 32'(irq), 32'h0);
    chk("sw1_link_up", 32'(link_up), 32'h0);
    rd_addr = 5'd5;
    tick(1);
    chk("sw1_rd5", 32'(rd_data), 32'h1005);

    // Second sweep, only register 3 differs.
    for (int n = 0; n < 32; n++) begin
      send_wait(5'(n), (n == 3) ? 16'hBEEF : 16'h1000 + 16'(n));
      tick(1);
    end
    chk("sw2_changed", changed, 32'h8);
    chk("sw2_irq", 32'(irq), 32'h1);
    chk("sw2_count", 32'(sweep_count), 32'd2);
    chk("sw2_pulses", 32'(sd_cnt), 32'd2);

    // Readback of the whole mirror against the expected image.
    for (int n = 0; n < 32; n++)
      exp_q.push_back((n == 3) ? 32'hBEEF : 32'h1000 + 32'(n));
    for (int n = 0; n < 32; n++) begin
      rd_addr = 5'(n);
      tick(1);
      chk("readback", 32'(rd_data), exp_q.pop_front());
    end

    // Clear, irq drops the next cycle.
    clr = 32'h8;
    chk("clr_irq_before", 32'(irq), 32'h1);
    tick(1);
    clr = '0;
    chk("clr_changed", changed, 32'h0);
    chk("clr_irq_after", 32'(irq), 32'h0);

    // Set and clear of bit 3 at the same edge: set wins.
    send(5'd3, 16'h1234);
    tick(1);
    clr = 32'h8;
    tick(1);
    clr = '0;
    chk("setwins_changed", changed, 32'h8);
    clear_all();
    chk("setwins_cleared", changed, 32'h0);

    // Link register sequence (mirror[1] currently 16'h1001, link bit 0).
    link_case("link_0000", 16'h0000, 0, 1'b0);
    link_case("link_0004", 16'h0004, 1, 1'b1);
    link_case("link_0004_rep", 16'h0004, 0, 1'b1);
    link_case("link_0000_down", 16'h0000, 1, 1'b0);
    clear_all();

    // Back-to-back on addr 7, previously AAAA.
    send_wait(5'd7, 16'hAAAA);
    clear_all();
    strobe = 1'b1; addr = 5'd7; data = 16'hAAAA;
    tick(1);
    data = 16'h5555;
    tick(1);
    strobe = 1'b0;
    tick(1);
    rd_addr = 5'd7;
    chk("b2b_first_chg", 32'(changed[7]), 32'h0);
    tick(1);
    chk("b2b_second_chg", 32'(changed[7]), 32'h1);
    chk("b2b_rd_precommit", 32'(rd_data), 32'hAAAA);
    tick(1);
    chk("b2b_rd_final", 32'(rd_data), 32'h5555);

    // Back-to-back identical values: second must compare against the first.
    clear_all();
    strobe = 1'b1; addr = 5'd7; data = 16'h1111;
    tick(2);
    strobe = 1'b0;
    tick(1);
    chk("fwd_first_chg", 32'(changed[7]), 32'h1);
    clr = 32'h80;
    tick(1);
    clr = '0;
    chk("fwd_second_nochg", 32'(changed[7]), 32'h0);
    tick(1);
    chk("fwd_rd", 32'(rd_data), 32'h1111);

    // Reset one cycle after a strobe: the capture is lost.
    send(5'd10, 16'hDEAD);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
    chk("rstmid_seen", seen, 32'h0);
    chk("rstmid_count", 32'(sweep_count), 32'h0);
    chk("rstmid_changed", changed, 32'h0);
    chk("rstmid_link_up", 32'(link_up), 32'h0);
    rd_addr = 5'd10;
    tick(1);
    chk("rstmid_mirror_kept", 32'(rd_data), 32'h100A);

    // Strobe coincident with the reset edge is ignored.
    rst = 1'b1; strobe = 1'b1; addr = 5'd10; data = 16'hBEEF;
    tick(1);
    rst = 1'b0; strobe = 1'b0;
    tick(4);
    chk("rstedge_seen", seen, 32'h0);

    // CHG_MASK bit 9 cleared on the second instance.
    send_wait(5'd9, 16'h0001);
    send_wait(5'd9, 16'h0002);
    chk("mask_full_chg9", 32'(changed[9]), 32'h1);
    chk("mask_off_chg9", 32'(changed_m[9]), 32'h0);
    chk("mask_off_seen9", 32'(seen_m[9]), 32'h1);
    chk("mask_off_irq", 32'(irq_m), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mii_reg_mirror.md
Name: mii_reg_mirror

Overview:
- Downstream consumer of the MDIO polling engine's `strobe`/`addr`/`data` output.
- Keeps a 32x16 mirror of all PHY management registers.
- Flags per-register value changes and tracks sweep completion.
- Derives link status and a level interrupt for the local bus/host logic, which reads the mirror through a registered read port.

Parameters:
- CHG_MASK, 32'hFFFF_FFFF, bit n=1 lets register n set its change flag.
- LINK_REG, 1, register index holding link status (BMSR).
- LINK_BIT, 2, bit within LINK_REG that is link-up.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- strobe  in  1  one-cycle pulse: addr/data valid.
- addr  in  5  PHY register index of captured data.
- data  in  16  captured register value.
- rd_addr  in  5  host read index.
- rd_data  out  16  mirror[rd_addr], registered.
- clr  in  32  write-1-to-clear pulse for changed flags.
- seen  out  32  bit n set once register n captured since reset.
- changed  out  32  sticky change flags.
- all_seen  out  1  &seen.
- sweep_done  out  1  one-cycle pulse when register 31 is committed.
- sweep_count  out  16  completed sweeps, wraps 16'hFFFF->0.
- link_up  out  1  mirror[LINK_REG][LINK_BIT] & seen[LINK_REG].
- link_event  out  1  one-cycle pulse on committed link_up change.
- irq  out  1  |changed.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears seen, changed, sweep_count, rd_data, sweep_done, link_event and all pipeline valids.
  - Mirror storage is NOT cleared; seen gates its use.
  - A strobe in flight during reset is discarded.
  - A strobe coincident with the rst edge is ignored.
- Capture pipeline, 2 stages:
  - T: strobe sampled.
  - T+1: stage-1 register holds addr/data and reads old = mirror[addr].
  - T+2: commit. mirror[addr]<=data and seen[addr]<=1.
  - At commit, changed[addr]<=1 iff seen[addr] & CHG_MASK[addr] & (old!=data).
  - The first capture of a register never sets changed.
  - All outputs reflect the commit at T+2, visible T+3 for registered flags.
- Forwarding:
  - Strobes may arrive on consecutive cycles.
  - If stage-1 addr equals the committing addr, old is taken from the committing data, not storage.
  - Compare/seen therefore behave as if strictly serialised.
- clr:
  - Bits clear the corresponding changed bits in the cycle presented.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- sweep_done:
  - Pulses in the commit cycle of addr==31.
  - sweep_count increments in that same cycle.
  - No check that 0..30 were seen; the ordering of incoming addresses is not enforced.
- link_up is combinational from the mirror and seen bits.
- link_event:
  - Pulses when a commit to LINK_REG changes link_up.
  - This includes the first capture (0->1 if the bit is set).
  - No pulse if the value is unchanged.
- rd_data:
  - One-cycle latency: rd_data(T+1) = mirror[rd_addr(T)].
  - A read of the address being committed in the same cycle returns the pre-commit value.
- irq is level, deasserts the cycle after the last changed bit clears.
- Widths: all compares are full 16-bit; sweep_count wraps modulo 2^16 silently.

Decomposition:
- Package mii_mirror_pkg:
  - NREG=32, AW=5, DW=16.
  - Default LINK_REG/LINK_BIT constants.
  - Pipeline stage record typedef (valid, addr, data, old).
- One sub-module, mii_mirror_ram:
  - 32x16 storage.
  - One write port.
  - One asynchronous read port (compare).
  - One synchronous read port (host).
  - Maps to distributed RAM.

Test Plan:
- Reset, then strobe addr=0..31 with data=16'h1000+n, 64 cycles apart:
  - all_seen rises after addr 31 commit.
  - sweep_done pulses once; sweep_count=1; changed=0; irq=0.
  - rd_addr=5 gives rd_data=16'h1005 next cycle.
- Second sweep with addr 3 data 16'hBEEF, others unchanged -> changed=32'h8, irq=1.
- clr=32'h8 -> changed=0; irq drops next cycle.
- addr 3 changes again in the same cycle that clr=32'h8 -> bit stays set.
- LINK_REG=1 writes:
  - 16'h0000 -> no link_event, link_up=0.
  - 16'h0004 -> link_event pulse, link_up=1.
  - 16'h0004 repeat -> no pulse.
  - 16'h0000 -> pulse, link_up=0.
- Back-to-back strobes, consecutive cycles, addr 7: data 16'hAAAA then 16'h5555 (7 previously seen as 16'hAAAA):
  - changed[7] set by the second only.
  - Mirror holds 16'h5555.
- Assert rst one cycle after a strobe -> seen=0, sweep_count=0, no commit observed.
- Then CHG_MASK bit 9 = 0 run: value change on addr 9 never sets changed[9].
